// File: rtl/cipher_match_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cipher_match_pkg
// Description : Shared constants and helpers for the cipher output-stage
//               match monitor: FSM state encoding, default widths and a
//               lowest-set-bit priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_match_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_TRIG  = 2'd2;

    // Default widths
    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 8;

    // Width of the priority encoder input; callers zero-extend their
    // vectors to this width, so NUM_PAT must not exceed it.
    localparam int LS_MAX_W = 64;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int lowest_set_idx(input logic [LS_MAX_W-1:0] vec);
        lowest_set_idx = 0;
        for (int i = LS_MAX_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set_idx = i;
            end
        end
    endfunction

endpackage : cipher_match_pkg
`default_nettype wire

// File: rtl/cipher_match_monitor_pattern_match_bank.sv
`default_nettype none
// ============================================================================
// Module      : pattern_match_bank
// Description : NUM_PAT programmable pattern/mask slots plus the
//               combinational per-slot masked compare against the incoming
//               cipher word.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               pat_we/pat_idx    - slot write strobe and slot index
//               pat_data/pat_mask - value and per-bit compare enable
//               pat_en            - per-slot enable (live level)
//               in_valid/in_data  - cipher output word under test
//               match_vec         - per-slot match result
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_match_bank
    import cipher_match_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_PAT = 4,
    parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               pat_we,
    input  logic [IDX_W-1:0]   pat_idx,
    input  logic [DATA_W-1:0]  pat_data,
    input  logic [DATA_W-1:0]  pat_mask,
    input  logic [NUM_PAT-1:0] pat_en,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic [NUM_PAT-1:0] match_vec
);

    generate
        for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
            logic [DATA_W-1:0] r_pat;
            logic [DATA_W-1:0] r_mask;

            // Indices at or above NUM_PAT never equal any slot number, so
            // such writes fall through untouched.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pat  <= '0;
                    r_mask <= '0;
                end else if (pat_we && (pat_idx == IDX_W'(i))) begin
                    r_pat  <= pat_data;
                    r_mask <= pat_mask;
                end
            end

            // Compare uses the registered pattern, so a same-cycle write
            // only affects the following word. An all-zero mask matches
            // every valid word.
            assign match_vec[i] = pat_en[i] & in_valid &
                                  ~(|((in_data ^ r_pat) & r_mask));
        end
    endgenerate

endmodule : pattern_match_bank
`default_nettype wire

// File: rtl/cipher_match_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cipher_match_monitor
// Description : Output-stage monitor for a pipelined block cipher. Registers
//               the cipher output stream, counts words hitting any of
//               NUM_PAT masked patterns, and on reaching a programmable
//               threshold raises a sticky trigger and freezes the output at
//               the last pre-trigger word.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               arm, clear          - monitoring enable level, clear pulse
//               thresh              - hit count that fires (0 acts as 1)
//               pat_we/idx/data/mask/en - pattern slot programming
//               in_valid, in_data   - cipher output stream
//               out_valid, out_data - registered stream (frozen on trigger)
//               trig, trig_idx      - sticky trigger and lowest hit slot
//               hit_count           - saturating qualifying hit count
// Config      : CIPHER_MATCH_SEQ_EN - when defined, hits count only in slot
//               order (sequence mode, internal seq_ptr); otherwise any
//               matching slot counts.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_match_monitor
    import cipher_match_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_PAT = 4,
    parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    parameter int CNT_W   = CNT_W_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               clear,
    input  logic [CNT_W-1:0]   thresh,
    input  logic               pat_we,
    input  logic [IDX_W-1:0]   pat_idx,
    input  logic [DATA_W-1:0]  pat_data,
    input  logic [DATA_W-1:0]  pat_mask,
    input  logic [NUM_PAT-1:0] pat_en,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               trig,
    output logic [IDX_W-1:0]   trig_idx,
    output logic [CNT_W-1:0]   hit_count
);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_hit_count;
    logic                r_trig;
    logic [IDX_W-1:0]    r_trig_idx;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;

    logic [NUM_PAT-1:0]  w_match_vec;
    logic [LS_MAX_W-1:0] w_match_ext;
    logic                w_any;
    logic [IDX_W-1:0]    w_low_idx;
    logic                w_hit;
    logic [CNT_W-1:0]    w_thr_eff;
    logic [CNT_W:0]      w_cnt_inc;
    logic                w_fire;
    logic                w_fire_now;

    pattern_match_bank #(
        .DATA_W  (DATA_W),
        .NUM_PAT (NUM_PAT),
        .IDX_W   (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .pat_we    (pat_we),
        .pat_idx   (pat_idx),
        .pat_data  (pat_data),
        .pat_mask  (pat_mask),
        .pat_en    (pat_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .match_vec (w_match_vec)
    );

    always_comb begin
        w_match_ext                = '0;
        w_match_ext[NUM_PAT-1:0]   = w_match_vec;
    end

    assign w_any     = |w_match_vec;
    assign w_low_idx = IDX_W'(lowest_set_idx(w_match_ext));

`ifdef CIPHER_MATCH_SEQ_EN
    // Sequence mode: only a match on the slot seq_ptr points at counts.
    logic [IDX_W-1:0]    r_seq_ptr;
    logic [LS_MAX_W-1:0] w_en_ext;
    logic [LS_MAX_W-1:0] w_en_above;
    logic [IDX_W-1:0]    w_first_en;
    logic [IDX_W-1:0]    w_next_en;

    always_comb begin
        w_en_ext              = '0;
        w_en_ext[NUM_PAT-1:0] = pat_en;
        w_en_above            = w_en_ext;
        for (int i = 0; i < LS_MAX_W; i++) begin
            if (i <= int'(r_seq_ptr)) begin
                w_en_above[i] = 1'b0;
            end
        end
        w_first_en = IDX_W'(lowest_set_idx(w_en_ext));
        // Next enabled slot above the pointer, wrapping to the lowest one.
        w_next_en  = (|w_en_above) ? IDX_W'(lowest_set_idx(w_en_above))
                                   : w_first_en;
    end

    assign w_hit = w_match_ext[r_seq_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_ptr <= '0;
        end else if (clear) begin
            r_seq_ptr <= '0;
        end else if ((r_state == ST_ARMED) && arm) begin
            if (w_hit) begin
                r_seq_ptr <= w_next_en;
            end else if (in_valid && !w_any) begin
                r_seq_ptr <= w_first_en;
            end
        end
    end
`else
    assign w_hit = w_any;
`endif

    // Fire check is done one bit wider so a saturated counter still
    // compares correctly against the threshold.
    assign w_thr_eff  = (thresh == '0) ? CNT_W'(1) : thresh;
    assign w_cnt_inc  = {1'b0, r_hit_count} + (CNT_W + 1)'(1);
    assign w_fire     = (w_cnt_inc >= {1'b0, w_thr_eff});
    assign w_fire_now = (r_state == ST_ARMED) && arm && w_hit && w_fire && !clear;

    // Control FSM, hit counter and trigger flags. clear has priority over
    // any hit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hit_count <= '0;
            r_trig      <= 1'b0;
            r_trig_idx  <= '0;
        end else if (clear) begin
            r_state     <= arm ? ST_ARMED : ST_IDLE;
            r_hit_count <= '0;
            r_trig      <= 1'b0;
            r_trig_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!arm) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        if (!(&r_hit_count)) begin
                            r_hit_count <= r_hit_count + CNT_W'(1);
                        end
                        if (w_fire) begin
                            r_state    <= ST_TRIG;
                            r_trig     <= 1'b1;
                            r_trig_idx <= w_low_idx;
                        end
                    end
                end
                ST_TRIG: begin
                    r_state <= ST_TRIG;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: pass-through except while triggered. The triggering
    // word is dropped, leaving the previous word on out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (clear || ((r_state != ST_TRIG) && !w_fire_now)) begin
            r_out_valid <= in_valid;
            r_out_data  <= in_data;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign trig      = r_trig;
    assign trig_idx  = r_trig_idx;
    assign hit_count = r_hit_count;

endmodule : cipher_match_monitor
`default_nettype wire
